// File: rtl/fwd_sub_bytes_seq.sv
// Sequential AES forward SubBytes: LANES S-boxes sweep the captured 16-byte state,
// LANES bytes per cycle, then present the registered result with a valid/ready handshake.

module FORWARD_SUBSTITUTION_BOX (
  input  logic [7:0] a,
  output logic [7:0] c
);
  // Entry 0 sits in the top byte, so entry a lives at bit offset (255-a)*8.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_pos;

  assign w_pos = {~a, 3'b000};
  assign c     = SBOX[w_pos +: 8];
endmodule

module fwd_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] inp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] sub_data,
  output logic         busy
);
  localparam int STEPS  = 16 / LANES;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [STEP_W-1:0]   r_step;
  logic [127:0]        r_work;
  logic [127:0]        r_sub;
  logic [127:0]        w_work_next;
  logic                w_in_fire;
  logic                w_last;
  logic [3:0]          w_idx      [LANES];
  logic [7:0]          w_lane_in  [LANES];
  logic [7:0]          w_lane_out [LANES];

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_in_fire = in_valid & in_ready;
  assign w_last    = (r_step == LAST_STEP);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sub_data  = r_sub;

  // Byte b of the state occupies bits [(15-b)*8 +: 8]; ~idx gives 15-idx.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_idx[gi]     = 4'(int'(r_step) * LANES + gi);
      assign w_lane_in[gi] = r_work[{~w_idx[gi], 3'b000} +: 8];

      FORWARD_SUBSTITUTION_BOX u_sbox (
        .a (w_lane_in[gi]),
        .c (w_lane_out[gi])
      );
    end
  endgenerate

  always_comb begin
    w_work_next = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_work_next[{~w_idx[l], 3'b000} +: 8] = w_lane_out[l];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_next = S_RUN;
      S_RUN:  if (w_last) w_state_next = S_DONE;
      S_DONE: begin
        if (out_ready) w_state_next = in_valid ? S_RUN : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_work  <= '0;
      r_sub   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_in_fire) begin
        r_work <= inp_data;
        r_step <= '0;
      end else if (r_state == S_RUN) begin
        r_work <= w_work_next;
        r_step <= r_step + 1'b1;
        // The output register only changes once the whole state is substituted.
        if (w_last) r_sub <= w_work_next;
      end
    end
  end
endmodule

// File: tb/tb_fwd_sub_bytes_seq.sv
// Directed bench for fwd_sub_bytes_seq: LANES=4 main instance plus LANES=1/16 latency builds.

module tb_fwd_sub_bytes_seq;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] inp_data, sub_data;

  logic         in_valid_1, in_ready_1, out_valid_1, busy_1;
  logic [127:0] sub_data_1;
  logic         in_valid_16, in_ready_16, out_valid_16, busy_16;
  logic [127:0] sub_data_16;
  logic [127:0] inp_data_x;
  logic         out_ready_x;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_sub_bytes_seq #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inp_data(inp_data), .out_valid(out_valid), .out_ready(out_ready),
    .sub_data(sub_data), .busy(busy)
  );

  fwd_sub_bytes_seq #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .inp_data(inp_data_x), .out_valid(out_valid_1), .out_ready(out_ready_x),
    .sub_data(sub_data_1), .busy(busy_1)
  );

  fwd_sub_bytes_seq #(.LANES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .inp_data(inp_data_x), .out_valid(out_valid_16), .out_ready(out_ready_x),
    .sub_data(sub_data_16), .busy(busy_16)
  );

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called right after a falling edge; returns right after the falling edge that shows out_valid.
  task automatic run_block(input string tag, input logic [127:0] din, input logic [127:0] exp);
    int lat;
    lat = 0;
    in_valid = 1'b1;
    inp_data = din;
    @(negedge clk);
    in_valid = 1'b0;
    inp_data = ~din;
    check_value({tag, "_busy_run"}, 128'(busy), 128'(1));
    check_value({tag, "_in_ready_run"}, 128'(in_ready), 128'(0));
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check_value({tag, "_latency"}, 128'(lat), 128'(4));
    check_value({tag, "_data"}, sub_data, exp);
    $display("blk %s in=%h out=%h lat=%0d", tag, din, sub_data, lat);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_value({tag, "_out_valid_drop"}, 128'(out_valid), 128'(0));
    check_value({tag, "_busy_idle"}, 128'(busy), 128'(0));
    $display("out %s handshake done busy=%0d", tag, busy);
  endtask

  initial begin
    int hits;
    int hit_n [2];
    logic [127:0] hit_d [2];
    int ov_after_rst;
    int lat1, lat16;
    logic [127:0] held;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inp_data = '0;
    in_valid_1 = 1'b0; in_valid_16 = 1'b0; out_ready_x = 1'b0; inp_data_x = '0;
    repeat (2) @(negedge clk);
    check_value("rst_in_ready", 128'(in_ready), 128'(1));
    check_value("rst_busy", 128'(busy), 128'(0));
    check_value("rst_out_valid", 128'(out_valid), 128'(0));
    check_value("rst_sub_data", sub_data, 128'h0);
    $display("rst in_ready=%0d busy=%0d out_valid=%0d", in_ready, busy, out_valid);

    // First rising edge after release must already accept.
    rst_n = 1'b1;
    run_block("zero", 128'h0, {16{8'h63}});
    release_out("zero");

    run_block("fips", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230);
    held = sub_data;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      inp_data = {16{8'haa}};
      @(negedge clk);
      check_value($sformatf("stall%0d_out_valid", i), 128'(out_valid), 128'(1));
      check_value($sformatf("stall%0d_data", i), sub_data, held);
      check_value($sformatf("stall%0d_in_ready", i), 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    $display("stall 10 cycles data=%h", sub_data);
    release_out("stall");
    check_value("stall_data_after", sub_data, 128'hd42711aee0bf98f1b8b45de51e415230);

    // Streaming: two blocks back to back, results five cycles apart.
    hits = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    inp_data = {16{8'h53}};
    @(negedge clk);
    inp_data = {16{8'hff}};
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (out_valid) begin
        if (hits < 2) begin
          hit_n[hits] = n;
          hit_d[hits] = sub_data;
        end
        hits++;
        $display("stream n=%0d out=%h", n, sub_data);
      end
      if (n == 5) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    check_value("stream_count", 128'(hits), 128'(2));
    if (hits >= 2) begin
      check_value("stream0_cycle", 128'(hit_n[0]), 128'(4));
      check_value("stream0_data", hit_d[0], {16{8'hed}});
      check_value("stream1_cycle", 128'(hit_n[1]), 128'(9));
      check_value("stream1_data", hit_d[1], {16{8'h16}});
    end
    check_value("stream_busy_end", 128'(busy), 128'(0));

    // Reset while the counter sits at step 2.
    in_valid = 1'b1;
    inp_data = {16{8'h01}};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_value("arst_busy", 128'(busy), 128'(0));
    check_value("arst_out_valid", 128'(out_valid), 128'(0));
    check_value("arst_in_ready", 128'(in_ready), 128'(1));
    check_value("arst_sub_data", sub_data, 128'h0);
    $display("arst busy=%0d sub_data=%h", busy, sub_data);
    @(negedge clk);
    rst_n = 1'b1;
    ov_after_rst = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) ov_after_rst++;
    end
    check_value("arst_no_out_valid", 128'(ov_after_rst), 128'(0));
    run_block("post_rst", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230);
    release_out("post_rst");

    // LANES=1 and LANES=16 builds side by side.
    lat1 = 0; lat16 = 0;
    in_valid_1 = 1'b1; in_valid_16 = 1'b1;
    inp_data_x = {16{8'h01}};
    @(negedge clk);
    in_valid_1 = 1'b0; in_valid_16 = 1'b0;
    inp_data_x = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (out_valid_1 && lat1 == 0) lat1 = n;
      if (out_valid_16 && lat16 == 0) lat16 = n;
    end
    check_value("l1_latency", 128'(lat1), 128'(16));
    check_value("l1_data", sub_data_1, {16{8'h7c}});
    check_value("l16_latency", 128'(lat16), 128'(1));
    check_value("l16_data", sub_data_16, {16{8'h7c}});
    $display("lanes1 lat=%0d out=%h lanes16 lat=%0d out=%h", lat1, sub_data_1, lat16, sub_data_16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end
endmodule
